// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU with iterative multiply/divide and HI/LO.
// Single-cycle ops issue back-to-back; mul/div hold in_ready low.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Err,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, FIX
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opb;
  logic               sa, sb, dz, div_q;

  logic [WIDTH-1:0]   alu_res;
  logic               illegal, is_mul, is_div, sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [WIDTH-1:0]   q, r, hi_n, lo_n;
  logic               accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Decode ALUOp/FuncCode and compute single-cycle results
  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    sgn     = 1'b0;
    unique case (1'b1)
      (ALUOp == 2'b00): alu_res = A + B;
      (ALUOp == 2'b01): alu_res = A - B;
      (ALUOp == 2'b10): begin
        case (FuncCode)
          6'h20: alu_res = A + B;
          6'h22: alu_res = A - B;
          6'h24: alu_res = A & B;
          6'h25: alu_res = A | B;
          6'h27: alu_res = ~(A | B);
          6'h2A: alu_res = ($signed(A) < $signed(B))
                           ? {{(WIDTH-1){1'b0}}, 1'b1}
                           : '0;
          6'h10: alu_res = HI;
          6'h12: alu_res = LO;
          6'h18: begin is_mul = 1'b1; sgn = 1'b1; end
          6'h19: is_mul = 1'b1;
          6'h1A: begin is_div = 1'b1; sgn = 1'b1; end
          6'h1B: is_div = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + {1'b0, (prod[0] ? opb : {WIDTH{1'b0}})};
  assign div_diff = prod[2*WIDTH-1:WIDTH-1] - {1'b0, opb};

  assign q = prod[WIDTH-1:0];
  assign r = prod[2*WIDTH-1:WIDTH];

  // Sign fix-up of the unsigned product / quotient / remainder
  always_comb begin
    hi_n = r;
    lo_n = q;
    if (div_q) begin
      lo_n = dz ? '1 : ((sa ^ sb) ? -q : q);
      hi_n = sa ? -r : r;
    end else if (sa ^ sb) begin
      {hi_n, lo_n} = -prod;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mul) state_n = MUL;
        if (accept && is_div) state_n = DIV;
      end
      MUL, DIV: if (cnt == '0) state_n = FIX;
      FIX:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Datapath, result and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Err       <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      cnt       <= '0;
      prod      <= '0;
      opb       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dz        <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            prod  <= {{WIDTH{1'b0}}, a_mag};
            opb   <= b_mag;
            sa    <= a_neg;
            sb    <= b_neg;
            dz    <= (B == '0);
            div_q <= is_div;
            cnt   <= CNT_W'(WIDTH - 1);
          end else if (accept) begin
            Result    <= alu_res;
            Zero      <= (alu_res == '0);
            Err       <= illegal;
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt - CNT_W'(1);
        end
        DIV: begin
          if (!div_diff[WIDTH])
            prod <= {div_diff[WIDTH-1:0],
                     prod[WIDTH-2:0], 1'b1};
          else
            prod <= {prod[2*WIDTH-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          HI        <= hi_n;
          LO        <= lo_n;
          Result    <= lo_n;
          Zero      <= (lo_n == '0);
          Err       <= div_q & dz;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised execute-stage ALU for the MIPS core.
- Decodes ALUOp/FuncCode internally and performs single-cycle arithmetic/logic operations.
- Adds an iterative multiply/divide engine with HI/LO registers and a valid/ready handshake.
- Sits between the ID/EX register and EX/MEM; the hazard unit stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width; legal values are even and >= 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request; high only in IDLE
- ALUOp  input  2  00 add, 01 sub, 10 use FuncCode, 11 reserved
- FuncCode  input  6  R-type funct field
- A  input  WIDTH  operand rs
- B  input  WIDTH  operand rt
- out_valid  output  1  one-cycle pulse; Result is valid
- Result  output  WIDTH  registered result
- Zero  output  1  registered (Result == 0)
- Err  output  1  registered; illegal op, qualified by out_valid
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state, including mid-iteration): state=IDLE, in_ready=1, out_valid=0, Result=0, Zero=0, Err=0, HI=0, LO=0, counter=0. An aborted operation leaves no trace.
- Accept: a request is accepted on a clk edge where in_valid && in_ready. Operands and op are captured at that edge. When in_ready=0, in_valid is ignored.
- Decode:
  - ALUOp 00: add.
  - ALUOp 01: sub.
  - ALUOp 10, FuncCode:
    - 20 add
    - 22 sub
    - 24 and
    - 25 or
    - 27 nor
    - 2A slt (signed; Result = {0..,1} or 0)
    - 10 mfhi
    - 12 mflo
    - 18 mult
    - 19 multu
    - 1A div
    - 1B divu
  - ALUOp 11 or any other funct: illegal.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no overflow flag.
- Single-cycle ops (add, sub, and, or, nor, slt, mfhi, mflo, illegal):
  - Result, Zero and Err are registered at the accept edge; out_valid=1 for the following cycle.
  - Latency is 1 edge. State stays IDLE and in_ready stays 1, so back-to-back issue is one per cycle.
  - Illegal op: Result=0, Zero=1, Err=1.
  - mfhi/mflo return the HI/LO value present at the accept edge.
- Multi-cycle ops, FSM IDLE -> MUL|DIV -> FIX -> IDLE:
  - Accept edge: latch operand magnitudes (signed ops) or raw values (unsigned ops); latch the sign flags; counter=WIDTH-1; in_ready drops to 0.
  - MUL: shift-add, one bit per edge. DIV: restoring, one quotient bit per edge. Each runs WIDTH edges, then goes to FIX.
  - FIX (1 edge):
    - Negate the 2*WIDTH product if sign(A) != sign(B).
    - Negate the quotient if sign(A) != sign(B); give the remainder the sign of A. Signed division truncates toward zero.
    - Write HI/LO; Result=LO; out_valid=1 next cycle; Err=0.
  - Return to IDLE.
  - Total latency from accept edge to out_valid cycle: WIDTH+1 edges. in_ready is low for exactly WIDTH+1 cycles after accept.
- Divide by zero (div or divu): LO = all ones, HI = A, Err=1. The op still takes the full WIDTH+1 edges.
- Signed div of most-negative by -1: LO = most-negative, HI = 0, Err=0 (wrap).
- HI/LO change only at a FIX edge or at reset.
- out_valid is never high for two consecutive cycles from the same op. There is no output backpressure.

Test Plan (WIDTH=32):
- Back-to-back single-cycle ops, one per cycle:
  - ALUOp=10, funct 20, A=7, B=5 -> Result=0000000C.
  - funct 27, A=0F0F0F0F, B=00FF00FF -> F000F000.
  - funct 2A, A=FFFFFFFF, B=1 -> 00000001.
  - ALUOp=01, A=B=9 -> Result=0, Zero=1.
  - Expect one out_valid per cycle, in_ready constant 1.
- mult, A=FFFFFFFD (-3), B=5:
  - in_ready low 33 cycles; out_valid 33 edges after accept.
  - HI=FFFFFFFF, LO=FFFFFFF1.
  - Then mflo -> Result=FFFFFFF1.
- div, A=FFFFFFF9 (-7), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- divu, A=64 hex, B=0 -> LO=FFFFFFFF, HI=00000064, Err=1.
- in_valid held high during a multu: no extra accepts occur; the next op is accepted exactly in the out_valid cycle.
- Illegal ALUOp=11 -> Result=0, Err=1.
- Reset mid-op: rst_n low 10 edges into a multu -> HI=LO=0, in_ready=1 immediately, no out_valid.
